sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the team's 16x8 FIFO.
//  Adds generic width and depth, an occupancy count, programmable almost-full/empty
//  flags, overflow/underflow pulses and a registered read-data valid strobe.
//  Used as the standard buffer between producer and consumer stages in one clock domain.
// PARAMETERS
//  WIDTH     8   data word width in bits (>=1)
//  DEPTH     16  number of entries; power of two, >=4
//  AF_LEVEL  14  almost_full asserts when count >= AF_LEVEL (1..DEPTH-1)
//  AE_LEVEL  2   almost_empty asserts when count <= AE_LEVEL (1..DEPTH-1)
// PORTS
//  clk           in   1           single clock, all logic on rising edge
//  rst           in   1           synchronous, active-high reset
//  we            in   1           write request
//  din           in   WIDTH       write data
//  re            in   1           read request
//  dout          out  WIDTH       read data, registered
//  dout_valid    out  1           dout updated this cycle (1-cycle pulse)
//  full          out  1           DEPTH entries held
//  empty         out  1           0 entries held
//  almost_full   out  1           count >= AF_LEVEL
//  almost_empty  out  1           count <= AE_LEVEL
//  count         out  AW+1        entries held, 0..DEPTH (AW = log2 DEPTH)
//  overflow      out  1           1-cycle pulse: write rejected because full
//  underflow     out  1           1-cycle pulse: read rejected because empty
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, count=0, dout=0, dout_valid=0, overflow=underflow=0.
//    So empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not cleared.
//  - rst wins over we/re in the same cycle. Reset mid-stream discards all entries.
//    The first read after reset returns only data written after reset.
//  - Pointers are AW+1 bits and wrap naturally at 2*DEPTH.
//    empty = (wr_ptr == rd_ptr).
//    full  = (MSBs differ and low AW bits are equal).
//  - Write accepted iff we && !full: mem[wr_ptr[AW-1:0]] <= din, then wr_ptr++.
//  - Read accepted iff re && !empty: dout <= mem[rd_ptr[AW-1:0]], rd_ptr++,
//    and dout_valid=1 next cycle.
//  - Read latency is 1 clk. dout holds its last value when no read is accepted.
//  - Acceptance uses the registered flags of the current cycle:
//    * full with we && re: the read is accepted, the write is rejected (overflow=1),
//      next count = DEPTH-1.
//    * empty with we && re: the write is accepted, the read is rejected (underflow=1),
//      next count = 1. No fall-through.
//    * otherwise, simultaneous accepted read and write leave count unchanged.
//  - count: +1 on write-only, -1 on read-only, unchanged otherwise.
//    It is a registered counter, not a pointer difference.
//  - almost_full and almost_empty are combinational compares on the registered count.
//  - overflow and underflow are registered single-cycle pulses in the cycle after
//    the rejected request. They are not sticky.
//  - No X propagation: a read of a never-written slot after reset is impossible
//    because of the empty gating.
// STRUCTURE
//  - Package fifo_pkg:
//    * clog2 function, used to derive AW from DEPTH;
//    * parameter checks (DEPTH a power of two; AF/AE levels in range) as a
//      generate-time error.
//  - Sub-module fifo_sdp_ram:
//    * simple dual-port RAM, WIDTH x DEPTH;
//    * one write port and one registered read port;
//    * no reset, so it infers block or distributed RAM.
//  - Top level holds the pointers, count, flag logic, pulse registers and dout_valid.
// TESTING
//  (defaults: WIDTH=8, DEPTH=16, AF=14, AE=2)
//  1. Reset, then idle
//     -> empty=1, full=0, count=0, almost_empty=1, dout=0x00, dout_valid=0.
//  2. Write 0x01..0x10 (16 words)
//     -> full=1 and count=16 after the 16th.
//     -> almost_full first asserts at count=14.
//     -> A 17th write (0xAA) gives overflow=1 for 1 cycle and the contents are unchanged.
//  3. Read 16 words from full
//     -> dout=0x01..0x10 in order, each 1 clk after re, with dout_valid high each cycle.
//     -> empty=1 after the last read.
//     -> A further re gives underflow=1 and dout stays 0x10.
//  4. Wrap: write 10, read 10, then write 16 and read 16
//     -> the data order is preserved across the pointer wrap.
//     -> full and empty are correct at wr_ptr=26, rd_ptr=10.
//  5. Simultaneous events:
//     -> we && re while full: read 0x01, write rejected, count 16->15.
//     -> we && re while empty: count 0->1, no dout_valid.
//     -> we && re at count=5: count stays 5.
//  6. Reset mid-operation at count=7
//     -> next cycle count=0, empty=1.
//     -> Then write 0x55 and read it -> dout=0x55 (no stale data returned).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: address-width derivation and
// elaboration-time parameter legality checks.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int width, input int depth,
                                     input int af_level, input int ae_level);
        return (width >= 1) && is_pow2(depth) && (depth >= 4) &&
               (af_level >= 1) && (af_level <= depth - 1) &&
               (ae_level >= 1) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage for the FIFO: one write port and one registered
// read port, sharing a single clock.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: neither the array nor the read register has a reset, so the tools
    // can map this onto block or distributed RAM; reads are gated by empty upstream.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty flags,
// overflow/underflow pulses and a registered read-data valid strobe.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    localparam logic [AW:0] AF_CNT = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT = (AW + 1)'(AE_LEVEL);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_accept;
    logic             rd_accept;
    logic             dout_live;
    logic [WIDTH-1:0] ram_rdata;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                          (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_accept = 1'b0;
        rd_accept = 1'b0;
        if (!rst) begin
            wr_accept = we && !full;
            rd_accept = re && !empty;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
            dout_live  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            overflow   <= we && full;
            underflow  <= re && empty;
            dout_valid <= rd_accept;
            if (rd_accept) begin
                dout_live <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    fifo_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (din),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_rdata)
    );

    // The RAM read register has no reset; dout reads as zero until the first
    // accepted read after reset, then holds the last word read.
    assign dout = dout_live ? ram_rdata : '0;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: expected read data is queued at issue
// time and compared by a monitor whenever dout_valid is seen.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             rst;
    logic             we;
    logic [WIDTH-1:0] din;
    logic             re;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .din          (din),
        .re           (re),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no end of test, expected finish before 1 ms");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every dout_valid must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dout_valid: got dout=%0h expected no output", dout);
            end else begin
                check("dout_order", dout, exp_q.pop_front());
            end
        end
    end

    // Inputs change on the falling edge and are consumed on the next rising edge.
    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r);
        we  = w;
        din = d;
        re  = r;
        @(negedge clk);
        we  = 1'b0;
        re  = 1'b0;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic rd(input logic [WIDTH-1:0] e);
        exp_q.push_back(e);
        cyc(1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        re  = 1'b0;
        din = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1. reset state
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_almost_full", almost_full, 0);
        check("rst_dout", dout, 8'h00);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_overflow", overflow, 0);

        // 2. fill, almost_full threshold, overflow
        for (int i = 1; i <= 16; i++) begin
            wr(8'(i));
            check("fill_count", count, i);
            check("fill_almost_full", almost_full, (i >= 14) ? 1 : 0);
            check("fill_almost_empty", almost_empty, (i <= 2) ? 1 : 0);
        end
        check("fill_full", full, 1);
        wr(8'hAA);
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 16);
        cyc(1'b0, '0, 1'b0);
        check("ovf_cleared", overflow, 0);

        // 3. drain, underflow, dout hold
        for (int i = 1; i <= 16; i++) begin
            rd(8'(i));
        end
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);
        cyc(1'b0, '0, 1'b1);
        check("udf_pulse", underflow, 1);
        check("udf_dout_hold", dout, 8'h10);
        check("udf_no_valid", dout_valid, 0);
        cyc(1'b0, '0, 1'b0);
        check("udf_cleared", underflow, 0);
        check("idle_dout_hold", dout, 8'h10);

        // 4. pointer wrap: full at wr_ptr=26, rd_ptr=10
        do_reset();
        check("wrap_rst_dout", dout, 8'h00);
        for (int i = 0; i < 10; i++) wr(8'(8'h20 + i));
        for (int i = 0; i < 10; i++) rd(8'(8'h20 + i));
        check("wrap_empty_10", empty, 1);
        for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
        check("wrap_full", full, 1);
        check("wrap_not_empty", empty, 0);
        check("wrap_count", count, 16);
        for (int i = 0; i < 16; i++) rd(8'(8'h40 + i));
        check("wrap_empty", empty, 1);
        check("wrap_not_full", full, 0);

        // 5. simultaneous read and write
        do_reset();
        for (int i = 1; i <= 16; i++) wr(8'(i));
        exp_q.push_back(8'h01);
        cyc(1'b1, 8'h77, 1'b1);
        check("sim_full_count", count, 15);
        check("sim_full_overflow", overflow, 1);
        check("sim_full_flag", full, 0);
        for (int i = 2; i <= 16; i++) rd(8'(i));
        check("sim_drained", empty, 1);
        cyc(1'b1, 8'h99, 1'b1);
        check("sim_empty_count", count, 1);
        check("sim_empty_underflow", underflow, 1);
        check("sim_empty_no_valid", dout_valid, 0);
        for (int i = 0; i < 4; i++) wr(8'(8'h9A + i));
        check("sim_mid_pre_count", count, 5);
        exp_q.push_back(8'h99);
        cyc(1'b1, 8'hA0, 1'b1);
        check("sim_mid_count", count, 5);
        rd(8'h9A);
        rd(8'h9B);
        rd(8'h9C);
        rd(8'h9D);
        rd(8'hA0);
        check("sim_end_empty", empty, 1);

        // 6. reset mid-stream, with a write in the reset cycle
        for (int i = 0; i < 7; i++) wr(8'(8'hB0 + i));
        check("mid_pre_count", count, 7);
        rst = 1'b1;
        we  = 1'b1;
        din = 8'hEE;
        @(negedge clk);
        rst = 1'b0;
        we  = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_dout", dout, 8'h00);
        wr(8'h55);
        check("mid_post_count", count, 1);
        rd(8'h55);
        check("mid_final_empty", empty, 1);

        repeat (2) @(negedge clk);
        check("outstanding_reads", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
